// File: rtl/sipo_8bit_pkg.sv
// Shared constants for the serial-in / parallel-out deserialiser.
//   SIPO_WIDTH : default register length in bits (width of the parallel bus)
package sipo_8bit_pkg;

  localparam int SIPO_WIDTH = 8;

endpackage

// File: rtl/sipo_8bit.sv
// sipo_8bit: serial-in / parallel-out shift register.
// Captures one serial bit per rising clock edge and always presents the most
// recent WIDTH captured bits on the parallel bus, oldest at the MSB and newest
// at bit 0. Shifting is unconditional; downstream logic decides when the bus
// holds a complete word.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset, clears the register
//   sin  : serial data in, sampled on every rising clk edge
//   pout : parallel register contents, driven directly from flops
module sipo_8bit
  import sipo_8bit_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] pout_q;
  logic [WIDTH-1:0] pout_d;

  // New bit enters at bit 0; bit WIDTH-1 falls off the top.
  always_comb begin
    pout_d = {pout_q[WIDTH-2:0], sin};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pout_q <= '0;
    end else begin
      pout_q <= pout_d;
    end
  end

  assign pout = pout_q;

endmodule

// File: tb/tb_sipo_8bit.sv
// Self-checking bench for sipo_8bit: directed scenarios followed by random
// serial traffic with occasional reset pulses, compared against a bit-history
// reference model.
module tb_sipo_8bit;

  logic       clk;
  logic       rst;
  logic       sin;
  logic [7:0] pout;

  int checks   = 0;
  int failures = 0;

  // Reference model: history of bits accepted since the last reset.
  logic hist[$];

  sipo_8bit #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .sin  (sin),
    .pout (pout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bus: the last eight accepted bits, newest at bit 0, zeros where
  // fewer than eight bits have arrived since reset.
  function automatic logic [7:0] model_exp();
    logic [7:0] e;
    int n;
    e = '0;
    n = hist.size();
    for (int i = 0; i < 8; i++) begin
      if (i < n) e[i] = hist[n-1-i];
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive sin, let one rising edge pass, check at
  // the next falling edge against the model.
  task automatic shift_bit(input logic b, input string tag);
    sin = b;
    @(posedge clk);
    if (rst) begin
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    @(negedge clk);
    check(tag, pout, model_exp());
  endtask

  // Called at a falling edge: reset asserted mid-low phase must clear pout
  // before the next rising edge, then released before that edge.
  task automatic reset_pulse(input string tag);
    #1 rst = 1'b0;
    #1 check(tag, pout, 8'h00);
    hist.delete();
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b0;
    sin = 1'b0;

    // 1. Reset held with sin toggling.
    #1 check("reset_initial", pout, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      shift_bit(logic'(i % 2 == 0), "reset_hold_model");
      check("reset_hold", pout, 8'h00);
    end

    // 2. Byte load 1,0,1,0,1,0,1,1.
    rst = 1'b1;
    pat = 8'b10101011;
    for (int i = 7; i >= 0; i--) shift_bit(pat[i], "byte_load_step");
    check("byte_load", pout, 8'b10101011);

    // 3. Continued shift.
    shift_bit(1'b0, "cont_shift_model");
    check("cont_shift", pout, 8'b01010110);

    // Async check while register holds a non-zero value.
    reset_pulse("async_reset");

    // 4. Walking one.
    shift_bit(1'b1, "walk_step");
    for (int i = 0; i < 7; i++) shift_bit(1'b0, "walk_step");
    check("walk_msb", pout, 8'b10000000);
    shift_bit(1'b0, "walk_drop_model");
    check("walk_drop", pout, 8'h00);

    // 5. All ones.
    for (int i = 0; i < 8; i++) shift_bit(1'b1, "ones_step");
    check("all_ones", pout, 8'hFF);
    shift_bit(1'b1, "ones_hold_model");
    check("ones_hold", pout, 8'hFF);

    // 6. Reset mid-operation.
    reset_pulse("pre_mid_reset");
    for (int i = 0; i < 4; i++) shift_bit(1'b1, "mid_step");
    check("mid_0f", pout, 8'h0F);
    reset_pulse("mid_reset");
    shift_bit(1'b1, "post_reset_model");
    check("post_reset", pout, 8'h01);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) reset_pulse("rand_reset");
      shift_bit(logic'($urandom_range(0, 1)), "rand_shift");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
